// File: rtl/arm_register_file_if.sv
// rtl/arm_register_file_if.sv - write/read/pc bus of the sixteen-entry ARM register file
interface arm_register_file_if #(
    parameter int DATA_W = 32
);
    logic [15:0]       we_onehot;
    logic [DATA_W-1:0] wr_data;
    logic [3:0]        ra_sel;
    logic [3:0]        rb_sel;
    logic              pc_inc;
    logic              err_clr;
    logic [DATA_W-1:0] ra_data;
    logic [DATA_W-1:0] rb_data;
    logic [DATA_W-1:0] pc_out;
    logic              we_err;

    modport master (
        output we_onehot, wr_data, ra_sel, rb_sel, pc_inc, err_clr,
        input  ra_data, rb_data, pc_out, we_err
    );

    modport slave (
        input  we_onehot, wr_data, ra_sel, rb_sel, pc_inc, err_clr,
        output ra_data, rb_data, pc_out, we_err
    );
endinterface

// File: rtl/arm_register_file.sv
// rtl/arm_register_file.sv - sixteen-entry register file with R15 program counter path
module arm_register_file #(
    parameter int DATA_W = 32,
    parameter int PC_INC = 4
) (
    input logic                clk,
    input logic                rst_n,
    arm_register_file_if.slave bus
);
    localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(PC_INC);

    logic [DATA_W-1:0] regs [16];
    logic              we_err_q;
    logic              sel_any;
    logic              sel_single;
    logic              wr_legal;
    logic              wr_illegal;

    // A vector is one-hot when it is non-zero and clearing its lowest set bit leaves zero.
    always_comb begin
        sel_any    = (bus.we_onehot != 16'h0000);
        sel_single = ((bus.we_onehot & (bus.we_onehot - 16'h0001)) == 16'h0000);
        wr_legal   = sel_any && sel_single;
        wr_illegal = sel_any && !sel_single;
    end

    // Register array: legal writes commit, R15 otherwise advances when pc_inc is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 15; i++) begin
                if (wr_legal && bus.we_onehot[i]) begin
                    regs[i] <= bus.wr_data;
                end
            end
            if (wr_legal && bus.we_onehot[15]) begin
                regs[15] <= bus.wr_data;
            end else if (bus.pc_inc) begin
                regs[15] <= regs[15] + PC_STEP;
            end
        end
    end

    // Sticky multi-hot flag; a fresh illegal vector outranks a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_err_q <= 1'b0;
        end else if (wr_illegal) begin
            we_err_q <= 1'b1;
        end else if (bus.err_clr) begin
            we_err_q <= 1'b0;
        end
    end

    // Read ports are plain muxes of committed state, no write bypass.
    always_comb begin
        bus.ra_data = regs[bus.ra_sel];
        bus.rb_data = regs[bus.rb_sel];
        bus.pc_out  = regs[15];
        bus.we_err  = we_err_q;
    end
endmodule

// File: tb/tb_arm_register_file.sv
// tb/tb_arm_register_file.sv - table and scoreboard bench for arm_register_file
module tb_arm_register_file;
    logic clk;
    logic rst_n;

    arm_register_file_if #(.DATA_W(32)) bus ();

    arm_register_file #(.DATA_W(32), .PC_INC(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] we;
        logic [31:0] wd;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic        inc;
        logic        clr;
        logic [31:0] exp_ra;
        logic [31:0] exp_rb;
        logic [31:0] exp_pc;
        logic        exp_err;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    vec_t vecs [20];
    exp_t sb [$];
    int   errors = 0;
    int   checks = 0;

    task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, req);
        end
    endtask

    task automatic check_all(input int idx, input logic [31:0] ra, input logic [31:0] rb,
                             input logic [31:0] pc, input logic err);
        cmp("ra_data", idx, bus.ra_data, ra);
        cmp("rb_data", idx, bus.rb_data, rb);
        cmp("pc_out", idx, bus.pc_out, pc);
        cmp("we_err", idx, {31'b0, bus.we_err}, {31'b0, err});
    endtask

    task automatic apply(input int idx, input vec_t v);
        exp_t e;
        bus.we_onehot = v.we;
        bus.wr_data   = v.wd;
        bus.ra_sel    = v.ra;
        bus.rb_sel    = v.rb;
        bus.pc_inc    = v.inc;
        bus.err_clr   = v.clr;
        e.idx = idx; e.ra = v.exp_ra; e.rb = v.exp_rb; e.pc = v.exp_pc; e.err = v.exp_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard[%0d]: queue empty, expected one entry", idx);
        end else begin
            e = sb.pop_front();
            check_all(e.idx, e.ra, e.rb, e.pc, e.err);
        end
    endtask

    function automatic vec_t mk(logic [15:0] we, logic [31:0] wd, logic [3:0] ra, logic [3:0] rb,
                                logic inc, logic clr, logic [31:0] era, logic [31:0] erb,
                                logic [31:0] epc, logic eerr);
        vec_t v;
        v.we = we; v.wd = wd; v.ra = ra; v.rb = rb; v.inc = inc; v.clr = clr;
        v.exp_ra = era; v.exp_rb = erb; v.exp_pc = epc; v.exp_err = eerr;
        return v;
    endfunction

    initial begin
        vecs[0]  = mk(16'h0000, 32'h0,        4'd3,  4'd3,  0, 0, 32'h0,        32'h0,        32'h0,        0);
        vecs[1]  = mk(16'h0008, 32'hDEADBEEF, 4'd3,  4'd3,  0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        0);
        vecs[2]  = mk(16'h0000, 32'h0,        4'd2,  4'd4,  0, 0, 32'h0,        32'h0,        32'h0,        0);
        vecs[3]  = mk(16'h0000, 32'h0,        4'd3,  4'd15, 1, 0, 32'hDEADBEEF, 32'h4,        32'h4,        0);
        vecs[4]  = mk(16'h0000, 32'h0,        4'd15, 4'd15, 1, 0, 32'h8,        32'h8,        32'h8,        0);
        vecs[5]  = mk(16'h0000, 32'h0,        4'd0,  4'd1,  1, 0, 32'h0,        32'h0,        32'hC,        0);
        vecs[6]  = mk(16'h8000, 32'hFFFFFFFC, 4'd15, 4'd3,  0, 0, 32'hFFFFFFFC, 32'hDEADBEEF, 32'hFFFFFFFC, 0);
        vecs[7]  = mk(16'h0000, 32'h0,        4'd15, 4'd3,  1, 0, 32'h0,        32'hDEADBEEF, 32'h0,        0);
        vecs[8]  = mk(16'h8000, 32'h00001000, 4'd15, 4'd15, 1, 0, 32'h1000,     32'h1000,     32'h1000,     0);
        vecs[9]  = mk(16'h0001, 32'h11111111, 4'd0,  4'd15, 0, 0, 32'h11111111, 32'h1000,     32'h1000,     0);
        vecs[10] = mk(16'h0002, 32'h22222222, 4'd0,  4'd1,  0, 0, 32'h11111111, 32'h22222222, 32'h1000,     0);
        vecs[11] = mk(16'h0003, 32'h5A5A5A5A, 4'd0,  4'd1,  1, 0, 32'h11111111, 32'h22222222, 32'h1004,     1);
        vecs[12] = mk(16'h0000, 32'h0,        4'd15, 4'd0,  0, 0, 32'h1004,     32'h11111111, 32'h1004,     1);
        vecs[13] = mk(16'h0000, 32'h0,        4'd1,  4'd2,  0, 0, 32'h22222222, 32'h0,        32'h1004,     1);
        vecs[14] = mk(16'h0000, 32'h0,        4'd0,  4'd1,  0, 1, 32'h11111111, 32'h22222222, 32'h1004,     0);
        vecs[15] = mk(16'h0300, 32'h77777777, 4'd8,  4'd9,  0, 0, 32'h0,        32'h0,        32'h1004,     1);
        vecs[16] = mk(16'h0300, 32'h77777777, 4'd8,  4'd9,  0, 1, 32'h0,        32'h0,        32'h1004,     1);
        vecs[17] = mk(16'h0000, 32'h0,        4'd8,  4'd9,  0, 1, 32'h0,        32'h0,        32'h1004,     0);
        vecs[18] = mk(16'hFFFF, 32'h99999999, 4'd15, 4'd0,  0, 0, 32'h1004,     32'h11111111, 32'h1004,     1);
        vecs[19] = mk(16'h4000, 32'hABCD0123, 4'd14, 4'd13, 0, 0, 32'hABCD0123, 32'h0,        32'h1004,     1);

        rst_n = 1'b0;
        bus.we_onehot = '0; bus.wr_data = '0; bus.ra_sel = '0; bus.rb_sel = '0;
        bus.pc_inc = 1'b0; bus.err_clr = 1'b0;
        #2;
        check_all(100, 32'h0, 32'h0, 32'h0, 1'b0);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            apply(i, vecs[i]);
        end

        // Reset between edges with a write and increment pending.
        bus.we_onehot = 16'h0020; bus.wr_data = 32'hCAFEF00D;
        bus.ra_sel = 4'd14; bus.rb_sel = 4'd0; bus.pc_inc = 1'b1; bus.err_clr = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check_all(200, 32'h0, 32'h0, 32'h0, 1'b0);
        bus.ra_sel = 4'd5;
        @(posedge clk);
        #1;
        check_all(201, 32'h0, 32'h0, 32'h0, 1'b0);
        bus.we_onehot = '0; bus.pc_inc = 1'b0;
        #2 rst_n = 1'b1;
        apply(202, mk(16'h0000, 32'h0,        4'd5, 4'd15, 0, 0, 32'h0,        32'h0, 32'h0, 0));
        apply(203, mk(16'h0020, 32'hCAFEF00D, 4'd5, 4'd15, 0, 0, 32'hCAFEF00D, 32'h0, 32'h0, 0));
        apply(204, mk(16'h0000, 32'h0,        4'd5, 4'd5,  1, 0, 32'hCAFEF00D, 32'hCAFEF00D, 32'h4, 0));

        if (sb.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
